// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map, CTRL bit positions and reset values for avalon_pwm_multi
package pwm_pkg;

    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_PRESC  = 2;
    localparam int REG_PERIOD = 3;
    localparam int REG_DUTY0  = 4;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_INV_LSB    = 8;
    localparam int STATUS_WRAP_BIT = 0;

    // Every register, shadow, active copy and counter resets to zero.
    localparam logic [31:0] RST_VAL = 32'h0;

endpackage

// File: rtl/pwm_channel_cmp.sv
// rtl/pwm_channel_cmp.sv - per-channel active duty copy and registered compare output
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] duty_sh,
    input  logic             load,
    input  logic             en,
    input  logic             inv,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_out
);

    logic [CNT_W-1:0] duty_act_q, duty_act_d;
    logic             pwm_q, pwm_d;

    always_comb begin
        duty_act_d = load ? duty_sh : duty_act_q;
        pwm_d      = en & ((cnt < duty_act_q) ^ inv);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_act_q <= RST_VAL[CNT_W-1:0];
            pwm_q      <= RST_VAL[0];
        end else begin
            duty_act_q <= duty_act_d;
            pwm_q      <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;

endmodule

// File: rtl/avalon_pwm_multi.sv
// rtl/avalon_pwm_multi.sv - multi-channel double-buffered PWM behind an Avalon-MM slave
module avalon_pwm_multi #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 12,
    parameter int PRESC_W = 16,
    parameter int ADDR_W  = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);
    import pwm_pkg::*;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(REG_CTRL);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(REG_STATUS);
    localparam logic [ADDR_W-1:0] A_PRESC  = ADDR_W'(REG_PRESC);
    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(REG_PERIOD);

    logic              en_q, en_d;
    logic              irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] inv_q, inv_d;
    logic              wrap_flag_q, wrap_flag_d;

    logic [PRESC_W-1:0] presc_sh_q, presc_sh_d;
    logic [CNT_W-1:0]   period_sh_q, period_sh_d;
    logic [CNT_W-1:0]   duty_sh_q [NUM_CH];
    logic [CNT_W-1:0]   duty_sh_d [NUM_CH];

    logic [PRESC_W-1:0] presc_act_q, presc_act_d;
    logic [CNT_W-1:0]   period_act_q, period_act_d;
    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic wr_en;
    logic tick;
    logic wrap;
    logic load;
    logic unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        inv_d       = inv_q;
        presc_sh_d  = presc_sh_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        if (wr_en && address == A_CTRL) begin
            en_d     = writedata[CTRL_EN_BIT];
            irq_en_d = writedata[CTRL_IRQ_EN_BIT];
            inv_d    = writedata[CTRL_INV_LSB +: NUM_CH];
        end
        if (wr_en && address == A_PRESC)
            presc_sh_d = writedata[PRESC_W-1:0];
        if (wr_en && address == A_PERIOD)
            period_sh_d = writedata[CNT_W-1:0];
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_en && address == ADDR_W'(REG_DUTY0 + i))
                duty_sh_d[i] = writedata[CNT_W-1:0];
        end
    end

    // While disabled the active copies follow the shadows every cycle.
    always_comb begin
        tick = en_q && (presc_cnt_q == presc_act_q);
        wrap = tick && (cnt_q == period_act_q);
        load = ~en_q | wrap;

        if (!en_q || tick)
            presc_cnt_d = '0;
        else
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);

        if (!en_q || wrap)
            cnt_d = '0;
        else if (tick)
            cnt_d = cnt_q + CNT_W'(1);
        else
            cnt_d = cnt_q;

        presc_act_d  = load ? presc_sh_q  : presc_act_q;
        period_act_d = load ? period_sh_q : period_act_q;

        // A wrap in the same cycle as a clear keeps the flag set.
        wrap_flag_d = wrap_flag_q;
        if (wr_en && address == A_STATUS && writedata[STATUS_WRAP_BIT])
            wrap_flag_d = 1'b0;
        if (wrap)
            wrap_flag_d = 1'b1;
    end

    always_comb begin
        readdata = '0;
        if (address == A_CTRL) begin
            readdata[CTRL_EN_BIT]              = en_q;
            readdata[CTRL_IRQ_EN_BIT]          = irq_en_q;
            readdata[CTRL_INV_LSB +: NUM_CH]   = inv_q;
        end
        if (address == A_STATUS)
            readdata[STATUS_WRAP_BIT] = wrap_flag_q;
        if (address == A_PRESC)
            readdata[PRESC_W-1:0] = presc_sh_q;
        if (address == A_PERIOD)
            readdata[CNT_W-1:0] = period_sh_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_W'(REG_DUTY0 + i))
                readdata[CNT_W-1:0] = duty_sh_q[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q         <= RST_VAL[0];
            irq_en_q     <= RST_VAL[0];
            inv_q        <= RST_VAL[NUM_CH-1:0];
            wrap_flag_q  <= RST_VAL[0];
            presc_sh_q   <= RST_VAL[PRESC_W-1:0];
            period_sh_q  <= RST_VAL[CNT_W-1:0];
            duty_sh_q    <= '{default: RST_VAL[CNT_W-1:0]};
            presc_act_q  <= RST_VAL[PRESC_W-1:0];
            period_act_q <= RST_VAL[CNT_W-1:0];
            presc_cnt_q  <= RST_VAL[PRESC_W-1:0];
            cnt_q        <= RST_VAL[CNT_W-1:0];
        end else begin
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            inv_q        <= inv_d;
            wrap_flag_q  <= wrap_flag_d;
            presc_sh_q   <= presc_sh_d;
            period_sh_q  <= period_sh_d;
            duty_sh_q    <= duty_sh_d;
            presc_act_q  <= presc_act_d;
            period_act_q <= period_act_d;
            presc_cnt_q  <= presc_cnt_d;
            cnt_q        <= cnt_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel_cmp #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .duty_sh (duty_sh_q[g]),
            .load    (load),
            .en      (en_q),
            .inv     (inv_q[g]),
            .cnt     (cnt_q),
            .pwm_out (pwm_out[g])
        );
    end

    assign irq = wrap_flag_q & irq_en_q;

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// tb/tb_avalon_pwm_multi.sv - directed self-checking bench for avalon_pwm_multi
module tb_avalon_pwm_multi;

    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [3:0]        pwm_out;
    logic              irq;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    avalon_pwm_multi #(
        .NUM_CH(4), .CNT_W(12), .PRESC_W(16), .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    // PERIOD=9, PRESC=0: pwm after edge kk reflects cnt=(kk-1)%10; DUTY0 goes 3->7 at the wrap on edge 30.
    function automatic logic [3:0] exp_a(input int kk);
        int j;
        int d0;
        j  = (kk - 1) % 10;
        d0 = (kk - 1 >= 30) ? 7 : 3;
        return {j < 5, 1'b1, 1'b0, j < d0};
    endfunction

    // PRESC=2, PERIOD=3, DUTY0=2: cnt advances every 3 clk, 12-clk period.
    function automatic logic [3:0] exp_b(input int kk);
        return {1'b1, 1'b1, 1'b0, (((kk - 1) / 3) % 4) < 2};
    endfunction

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pwm", pwm_out, 4'h0);
        check("rst_irq", irq, 1'b0);
        reset_n = 1'b1;
        for (int a = 0; a < 8; a++) rd("rst_read", ADDR_W'(a), 32'h0);

        wr(3'd2, 32'd0);
        wr(3'd3, 32'd9);
        wr(3'd4, 32'd3);
        wr(3'd5, 32'd0);
        wr(3'd6, 32'd10);
        wr(3'd7, 32'hFFFF_F005);
        rd("duty3_trunc", 3'd7, 32'd5);
        rd("period_rd", 3'd3, 32'd9);

        wr(3'd0, 32'h1);
        k = 0;
        while (k < 24) begin
            step();
            check("pwm_basic", pwm_out, exp_a(k));
        end
        check("irq_off", irq, 1'b0);
        rd("wrap_set", 3'd1, 32'h1);

        wr(3'd4, 32'd7);
        check("pwm_upd_wr", pwm_out, exp_a(k));
        rd("duty0_sh", 3'd4, 32'd7);
        while (k < 40) begin
            step();
            check("pwm_upd", pwm_out, exp_a(k));
        end

        wr(3'h0, 32'h201);
        check("inv_lag", pwm_out, exp_a(k));
        rd("ctrl_inv", 3'd0, 32'h201);
        repeat (4) begin
            step();
            check("pwm_inv", pwm_out, exp_a(k) | 4'b0010);
        end

        wr(3'd0, 32'h200);
        repeat (3) begin
            step();
            check("pwm_dis", pwm_out, 4'h0);
        end

        wr(3'd2, 32'd2);
        wr(3'd3, 32'd3);
        wr(3'd4, 32'd2);
        wr(3'd0, 32'h1);
        k = 0;
        while (k < 24) begin
            step();
            check("pwm_presc", pwm_out, exp_b(k));
        end

        rd("wrap_b", 3'd1, 32'h1);
        wr(3'd1, 32'h1);
        rd("wrap_clr", 3'd1, 32'h0);
        wr(3'd0, 32'h3);
        check("irq_clr", irq, 1'b0);
        while (k < 35) step();
        rd("wrap_pre", 3'd1, 32'h0);
        wr(3'd1, 32'h1);
        rd("wrap_win", 3'd1, 32'h1);
        check("irq_set", irq, 1'b1);
        wr(3'd1, 32'h0);
        rd("wrap_w0", 3'd1, 32'h1);
        wr(3'd1, 32'h1);
        rd("wrap_clr2", 3'd1, 32'h0);
        check("irq_clr2", irq, 1'b0);
        check("pwm_pre_rst", pwm_out, exp_b(k));

        #2;
        reset_n = 1'b0;
        #1;
        check("async_pwm", pwm_out, 4'h0);
        check("async_irq", irq, 1'b0);
        for (int a = 0; a < 8; a++) rd("rst2_read", ADDR_W'(a), 32'h0);
        step();
        reset_n = 1'b1;
        step();
        check("post_rst_pwm", pwm_out, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
